// File: rtl/key_sw_pkg.sv
// Shared register map and bus types for the pushbutton/switch input agent.
package key_sw_pkg;

    typedef logic [2:0] addr_t;

    localparam addr_t ADDR_DATA     = 3'd0;
    localparam addr_t ADDR_KEY_EDGE = 3'd1;
    localparam addr_t ADDR_KEY_MASK = 3'd2;
    localparam addr_t ADDR_SW_EDGE  = 3'd3;
    localparam addr_t ADDR_ID       = 3'd4;

    localparam logic [31:0] KEY_SW_ID = 32'h4B53_0001;

endpackage

// File: rtl/debounce_bit.sv
// Two-flop synchronizer plus counter debouncer for one input bit.
// rise/fall are combinational strobes, valid in the cycle before stable changes.
module debounce_bit #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta;
    logic             sync;
    logic [CNT_W-1:0] cnt;
    logic             settle;

    assign settle = (sync != stable) && (cnt == CNT_MAX);
    assign rise   = settle & sync;
    assign fall   = settle & ~sync;

    // Counter only advances while sync disagrees with stable, so it never passes CNT_MAX.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            meta <= raw;
            sync <= meta;
            if (sync == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= sync;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/key_sw_agent.sv
// Avalon-MM responder exposing debounced KEY/SW levels, sticky edge registers
// and a maskable key-press interrupt to the HPS lightweight bridge.
module key_sw_agent
    import key_sw_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned N_KEY           = 4,
    parameter int unsigned N_SW            = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  addr_t             address,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    input  logic [N_KEY-1:0]  key,
    input  logic [N_SW-1:0]   sw
);

    logic [N_KEY-1:0] key_db, key_rise, key_fall;
    logic [N_SW-1:0]  sw_db, sw_rise, sw_fall;
    logic [N_KEY-1:0] key_edge, key_mask;
    logic [N_SW-1:0]  sw_edge;

    logic             wr_c, rd_c;
    logic [N_KEY-1:0] key_clr_c;
    logic [N_SW-1:0]  sw_clr_c;
    logic [31:0]      rdata_c;
    logic             unused_bits;

    // Keys enter the debouncer inverted so that 1 = pressed and reset means released.
    for (genvar i = 0; i < N_KEY; i++) begin : g_key
        debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk    (clk),
            .reset_n(reset_n),
            .raw    (~key[i]),
            .stable (key_db[i]),
            .rise   (key_rise[i]),
            .fall   (key_fall[i])
        );
    end

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk    (clk),
            .reset_n(reset_n),
            .raw    (sw[i]),
            .stable (sw_db[i]),
            .rise   (sw_rise[i]),
            .fall   (sw_fall[i])
        );
    end

    assign unused_bits = ^{writedata, key_fall};

    // Decode strobes, W1C masks and read mux.
    always_comb begin
        wr_c      = chipselect & write;
        rd_c      = chipselect & read;
        key_clr_c = '0;
        sw_clr_c  = '0;
        rdata_c   = '0;
        if (wr_c && address == ADDR_KEY_EDGE) key_clr_c = writedata[N_KEY-1:0];
        if (wr_c && address == ADDR_SW_EDGE)  sw_clr_c  = writedata[N_SW-1:0];
        case (address)
            ADDR_DATA:     rdata_c = 32'({sw_db, key_db});
            ADDR_KEY_EDGE: rdata_c = 32'(key_edge);
            ADDR_KEY_MASK: rdata_c = 32'(key_mask);
            ADDR_SW_EDGE:  rdata_c = 32'(sw_edge);
            ADDR_ID:       rdata_c = KEY_SW_ID;
            default:       rdata_c = '0;
        endcase
    end

    // A new edge in the same cycle as its W1C leaves the bit set.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            key_edge <= '0;
            sw_edge  <= '0;
            key_mask <= '0;
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            key_edge <= (key_edge & ~key_clr_c) | key_rise;
            sw_edge  <= (sw_edge & ~sw_clr_c) | sw_rise | sw_fall;
            if (wr_c && address == ADDR_KEY_MASK) key_mask <= writedata[N_KEY-1:0];
            if (rd_c) readdata <= rdata_c;
            irq <= |(key_edge & key_mask);
        end
    end

endmodule

// File: tb/tb_key_sw_agent.sv
// Directed bench for key_sw_agent with a short debounce window.
module tb_key_sw_agent;
    import key_sw_pkg::*;

    localparam int unsigned DEB   = 8;
    localparam int unsigned NK    = 4;
    localparam int unsigned NS    = 10;

    logic          clk = 1'b0;
    logic          reset_n;
    addr_t         address;
    logic          chipselect, read, write;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic          irq;
    logic [NK-1:0] key;
    logic [NS-1:0] sw;
    logic [31:0]   rd;
    logic          irq_seen;

    int checks   = 0;
    int failures = 0;

    key_sw_agent #(.DEBOUNCE_CYCLES(DEB), .N_KEY(NK), .N_SW(NS)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq),
        .key       (key),
        .sw        (sw)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input addr_t a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        read       = 1'b1;
        tick();
        chipselect = 1'b0;
        read       = 1'b0;
        d          = readdata;
    endtask

    task automatic bus_write(input addr_t a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write      = 1'b1;
        tick();
        chipselect = 1'b0;
        write      = 1'b0;
        writedata  = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        check("rst_rdata", readdata, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n    = 1'b0;
        key        = '1;
        sw         = '0;
        address    = '0;
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        writedata  = '0;
        do_reset();

        // ID, DATA at idle, readdata hold
        bus_read(ADDR_ID, rd);
        check("id", rd, 32'h4B53_0001);
        repeat (3) tick();
        check("rd_hold", readdata, 32'h4B53_0001);
        bus_read(ADDR_DATA, rd);
        check("data_idle", rd, 32'h0);
        check("irq_idle", 32'(irq), 32'h0);

        // key[1] press: visible from the read issued 10 cycles after the change
        key = 4'b1101;
        for (int k = 0; k < 13; k++) begin
            bus_read(ADDR_DATA, rd);
            check("k1_data", rd, (k >= 10) ? 32'h2 : 32'h0);
            check("k1_irq_masked", 32'(irq), 32'h0);
        end
        bus_read(ADDR_KEY_EDGE, rd);
        check("k1_edge", rd, 32'h2);

        // mask then W1C
        bus_write(ADDR_KEY_MASK, 32'h2);
        check("irq_mask_edge", 32'(irq), 32'h0);
        tick();
        check("irq_mask_next", 32'(irq), 32'h1);
        bus_write(ADDR_KEY_EDGE, 32'h2);
        check("irq_w1c_edge", 32'(irq), 32'h1);
        tick();
        check("irq_w1c_next", 32'(irq), 32'h0);
        bus_read(ADDR_KEY_EDGE, rd);
        check("k1_edge_clr", rd, 32'h0);
        bus_read(ADDR_KEY_MASK, rd);
        check("mask_rd", rd, 32'h2);
        bus_write(ADDR_KEY_MASK, 32'hFFFF_FFFF);
        bus_read(ADDR_KEY_MASK, rd);
        check("mask_wide", rd, 32'hF);

        // release is not captured as an edge
        key = '1;
        repeat (12) tick();
        bus_read(ADDR_DATA, rd);
        check("k1_release_data", rd, 32'h0);
        bus_read(ADDR_KEY_EDGE, rd);
        check("k1_release_edge", rd, 32'h0);

        // 5-cycle glitch on key[0] with all masks on
        irq_seen = 1'b0;
        key = 4'b1110;
        repeat (5) begin tick(); irq_seen |= irq; end
        key = '1;
        repeat (12) begin tick(); irq_seen |= irq; end
        check("glitch_irq", 32'(irq_seen), 32'h0);
        bus_read(ADDR_DATA, rd);
        check("glitch_data", rd, 32'h0);
        bus_read(ADDR_KEY_EDGE, rd);
        check("glitch_edge", rd, 32'h0);

        // key[3] press polled on KEY_EDGE with irq enabled
        key = 4'b0111;
        for (int k = 0; k < 13; k++) begin
            bus_read(ADDR_KEY_EDGE, rd);
            check("k3_edge", rd, (k >= 10) ? 32'h8 : 32'h0);
            check("k3_irq", 32'(irq), (k >= 10) ? 32'h1 : 32'h0);
        end
        key = '1;
        bus_write(ADDR_KEY_MASK, 32'h0);
        tick();
        check("k3_irq_unmask", 32'(irq), 32'h0);

        // switches after reset
        do_reset();
        sw = 10'h201;
        repeat (12) tick();
        bus_read(ADDR_SW_EDGE, rd);
        check("sw_edge", rd, 32'h201);
        bus_read(ADDR_DATA, rd);
        check("sw_data", rd, 32'h2010);
        bus_write(ADDR_SW_EDGE, 32'h1);
        bus_read(ADDR_SW_EDGE, rd);
        check("sw_edge_w1c", rd, 32'h200);
        check("sw_irq", 32'(irq), 32'h0);

        // read-only and unmapped addresses
        bus_write(ADDR_DATA, 32'hFFFF_FFFF);
        bus_read(ADDR_DATA, rd);
        check("data_ro", rd, 32'h2010);
        bus_write(ADDR_ID, 32'h0);
        bus_read(ADDR_ID, rd);
        check("id_ro", rd, 32'h4B53_0001);
        bus_write(3'd5, 32'hFFFF_FFFF);
        for (int a = 5; a < 8; a++) begin
            bus_read(addr_t'(a), rd);
            check("unmapped", rd, 32'h0);
        end

        // W1C lands on the very edge key[2] debounces: edge wins
        do_reset();
        key = 4'b1011;
        repeat (9) tick();
        bus_write(ADDR_KEY_EDGE, 32'h4);
        bus_read(ADDR_KEY_EDGE, rd);
        check("edge_wins", rd, 32'h4);
        bus_write(ADDR_KEY_EDGE, 32'h4);
        bus_read(ADDR_KEY_EDGE, rd);
        check("edge_w1c_plain", rd, 32'h0);

        // reset in the middle of a pending press
        key = '1;
        repeat (12) tick();
        do_reset();
        key = 4'b1011;
        repeat (7) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 13; k++) begin
            bus_read(ADDR_KEY_EDGE, rd);
            check("abort_edge", rd, (k >= 10) ? 32'h4 : 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
